// File: rtl/aes_v2_mix_ctrl_pkg.sv
// aes_v2_mix_ctrl_pkg
//   Shared definitions for the MixColumns sequencer: controller state
//   encoding, the datapath word width and the requester index type.
//   No ports.
package aes_v2_mix_ctrl_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef logic src_t;    // requester index, 0 or 1

endpackage

// File: rtl/aes_v2_rr_arb2.sv
// aes_v2_rr_arb2
//   Two-way round-robin grant. When both requesters are valid, the one
//   pointed at wins. The pointer then moves to the other requester. It
//   moves only when a grant is issued, which is the same cycle as the
//   accept.
// Ports
//   clock   in   1   clock
//   reset   in   1   synchronous, active-high; pointer returns to req0
//   valid   in   2   request valid per requester
//   enable  in   1   arbitration allowed this cycle
//   grant   out  2   one-hot grant (zero when disabled or nothing valid)
module aes_v2_rr_arb2
    import aes_v2_mix_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);

    src_t ptr;  // requester favoured on contention

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        if (enable) begin
            if (valid[0] && valid[1]) begin
                grant[ptr] = 1'b1;
            end else begin
                grant = valid;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (grant[0]) begin
            ptr <= 1'b1;
        end else if (grant[1]) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/aes_v2_mix_ctrl.sv
// aes_v2_mix_ctrl
//   Shares one byte-serial MixColumns unit between two requesters. It accepts
//   one op at a time and holds its operands steady while the unit runs. The
//   result, or a watchdog error, is returned on a tagged response handshake.
//   The unit is flushed back to step 0 whenever it is not running an op.
// Ports
//   clock, reset                     clock; synchronous active-high reset
//   kill                             abandon in-flight op, drop response
//   req{0,1}_valid/_ready            request handshake (ready = accepted)
//   req{0,1}_rs1/_rs2/_enc/_id       operands, direction (1 = forward), tag
//   rsp_valid/rsp_ready              response handshake
//   rsp_src/rsp_id/rsp_data/rsp_err  response payload (err => data 0)
//   busy                             controller not idle
//   mix_flush/mix_flush_data         datapath flush and its value (0)
//   mix_valid/mix_rs1/mix_rs2/mix_enc  datapath operands (registered)
//   mix_ready/mix_result             datapath completion and result
module aes_v2_mix_ctrl
    import aes_v2_mix_ctrl_pkg::*;
#(
    parameter int ID_W    = 3,
    parameter int TIMEOUT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              kill,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_rs1,
    input  logic [DATA_W-1:0] req0_rs2,
    input  logic              req0_enc,
    input  logic [ID_W-1:0]   req0_id,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_rs1,
    input  logic [DATA_W-1:0] req1_rs2,
    input  logic              req1_enc,
    input  logic [ID_W-1:0]   req1_id,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_src,
    output logic [ID_W-1:0]   rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              mix_flush,
    output logic [DATA_W-1:0] mix_flush_data,
    output logic              mix_valid,
    output logic [DATA_W-1:0] mix_rs1,
    output logic [DATA_W-1:0] mix_rs2,
    output logic              mix_enc,
    input  logic              mix_ready,
    input  logic [DATA_W-1:0] mix_result
);

    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_next;
    logic [WDOG_W-1:0] wdog;
    logic [1:0]        grant;
    logic              accept;
    logic              wdog_hit;
    logic              abort;

    // Reset mid-op behaves like kill for this cycle's outputs.
    assign abort    = kill || reset;
    assign wdog_hit = (wdog == WDOG_W'(TIMEOUT - 1));

    aes_v2_rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .valid  ({req1_valid, req0_valid}),
        .enable ((state == ST_IDLE) && !abort),
        .grant  (grant)
    );

    assign accept         = |grant;
    assign req0_ready     = grant[0];
    assign req1_ready     = grant[1];
    assign busy           = (state != ST_IDLE);
    assign mix_valid      = (state == ST_RUN);
    assign rsp_valid      = (state == ST_RESP) && !abort;
    assign mix_flush_data = '0;

    always_comb begin
        state_next = state;
        mix_flush  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                mix_flush = 1'b1;
                if (accept) state_next = ST_RUN;
            end
            ST_RUN: begin
                // Completion and timeout both return the unit to step 0.
                if (mix_ready || wdog_hit) begin
                    mix_flush  = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort) begin
            mix_flush  = 1'b1;
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            wdog     <= '0;
            mix_rs1  <= '0;
            mix_rs2  <= '0;
            mix_enc  <= 1'b0;
            rsp_src  <= 1'b0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_next;

            if (accept) begin
                mix_rs1 <= grant[1] ? req1_rs1 : req0_rs1;
                mix_rs2 <= grant[1] ? req1_rs2 : req0_rs2;
                mix_enc <= grant[1] ? req1_enc : req0_enc;
                rsp_id  <= grant[1] ? req1_id  : req0_id;
                rsp_src <= grant[1];
                wdog    <= '0;
            end else if (state == ST_RUN) begin
                wdog <= wdog + WDOG_W'(1);
            end

            // A killed run leaves the previous response payload untouched.
            if (state == ST_RUN && !kill) begin
                if (mix_ready) begin
                    rsp_data <= mix_result;
                    rsp_err  <= 1'b0;
                end else if (wdog_hit) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_v2_mix_ctrl.sv
// tb_aes_v2_mix_ctrl
//   Directed bench for aes_v2_mix_ctrl. It contains a behavioural model of the
//   4-step MixColumns unit. The unit is ready at step 3, and a flush sends it
//   back to step 0. Test vectors are standard AES MixColumns columns with
//   hand-written results. Hand-written sequences cover round-robin order,
//   response back-pressure, kill, the watchdog and reset during a response.
module tb_aes_v2_mix_ctrl;

    localparam int ID_W    = 3;
    localparam int TIMEOUT = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic            kill;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [31:0]     req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic            req0_enc, req1_enc;
    logic [ID_W-1:0] req0_id, req1_id;
    logic            rsp_valid, rsp_ready, rsp_src, rsp_err;
    logic [ID_W-1:0] rsp_id;
    logic [31:0]     rsp_data;
    logic            busy, mix_flush, mix_valid, mix_enc, mix_ready;
    logic [31:0]     mix_flush_data, mix_rs1, mix_rs2, mix_result;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    aes_v2_mix_ctrl #(.ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .kill(kill),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1),
        .req0_rs2(req0_rs2), .req0_enc(req0_enc), .req0_id(req0_id),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1),
        .req1_rs2(req1_rs2), .req1_enc(req1_enc), .req1_id(req1_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .mix_flush(mix_flush), .mix_flush_data(mix_flush_data),
        .mix_valid(mix_valid), .mix_rs1(mix_rs1), .mix_rs2(mix_rs2),
        .mix_enc(mix_enc), .mix_ready(mix_ready), .mix_result(mix_result)
    );

    // ---------------- MixColumns datapath model ----------------
    logic [1:0] dp_step = 2'd0;
    logic       tie_low = 1'b0;     // forces mix_ready low for the watchdog test

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] r = 8'h00;
        logic [7:0] p = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r = r ^ p;
            p = xt(p);
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_fn(input logic [31:0] rs1, input logic [31:0] rs2,
                                           input logic enc);
        logic [7:0] a [4];
        logic [7:0] r [4];
        logic [3:0] c [4];
        a[0] = rs1[7:0];   a[1] = rs1[15:8];
        a[2] = rs2[23:16]; a[3] = rs2[31:24];
        if (enc) begin c[0] = 4'd2;  c[1] = 4'd3;  c[2] = 4'd1;  c[3] = 4'd1; end
        else     begin c[0] = 4'd14; c[1] = 4'd11; c[2] = 4'd13; c[3] = 4'd9; end
        for (int i = 0; i < 4; i++) begin
            r[i] = 8'h00;
            for (int j = 0; j < 4; j++) r[i] = r[i] ^ gm(a[(i + j) % 4], c[j]);
        end
        return {r[3], r[2], r[1], r[0]};
    endfunction

    always @(posedge clock) begin
        if (mix_flush)                         dp_step <= 2'd0;
        else if (mix_valid && dp_step != 2'd3) dp_step <= dp_step + 2'd1;
    end

    assign mix_ready  = !tie_low && mix_valid && (dp_step == 2'd3);
    assign mix_result = mix_ready ? mix_fn(mix_rs1, mix_rs2, mix_enc) : 32'hdeadbeef;

    // ---------------- helpers ----------------
    typedef struct {
        int          src;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        enc;
        logic [2:0]  id;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input int src, input logic v, input vec_t x);
        if (src == 0) begin
            req0_valid = v; req0_rs1 = x.rs1; req0_rs2 = x.rs2;
            req0_enc = x.enc; req0_id = x.id;
        end else begin
            req1_valid = v; req1_rs1 = x.rs1; req1_rs2 = x.rs2;
            req1_enc = x.enc; req1_id = x.id;
        end
    endtask

    function automatic logic ready_of(input int src);
        return (src == 0) ? req0_ready : req1_ready;
    endfunction

    // Raise the request and wait for its accept. Return in cycle T+1 with
    // the request inputs cleared, so they cannot feed through.
    task automatic accept_req(input vec_t x, input string tag, output bit ok);
        vec_t blank = '{src: x.src, rs1: 32'h0, rs2: 32'h0, enc: 1'b0, id: 3'd0, exp_data: 32'h0};
        drive_req(x.src, 1'b1, x);
        #1;
        ok = 1'b0;
        for (int w = 0; w < 20; w++) begin
            if (ready_of(x.src)) begin ok = 1'b1; break; end
            tick();
        end
        check({tag, " accepted"}, 32'(ok), 32'd1);
        if (ok) tick();
        drive_req(x.src, 1'b0, blank);
        #1;
    endtask

    // Count cycles from the accept (T) until rsp_valid appears.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input vec_t x, input string tag);
        bit ok;
        int lat;
        accept_req(x, tag, ok);
        if (!ok) return;
        check({tag, " mix_valid"}, 32'(mix_valid), 32'd1);
        check({tag, " mix_flush T+1"}, 32'(mix_flush), 32'd0);
        check({tag, " mix_rs1"}, mix_rs1, x.rs1);
        check({tag, " mix_rs2"}, mix_rs2, x.rs2);
        check({tag, " mix_enc"}, 32'(mix_enc), 32'(x.enc));
        wait_rsp(lat);
        check({tag, " latency"}, 32'(lat), 32'd5);
        check({tag, " rsp_data"}, rsp_data, x.exp_data);
        check({tag, " rsp_src"}, 32'(rsp_src), 32'(x.src));
        check({tag, " rsp_id"}, 32'(rsp_id), 32'(x.id));
        check({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check({tag, " idle after rsp"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int lat;
        int who;
        logic [31:0] held;
        vec_t none;

        vecs[0] = '{src: 0, rs1: 32'h000013db, rs2: 32'h45530000, enc: 1'b1, id: 3'd5, exp_data: 32'hbca14d8e};
        vecs[1] = '{src: 1, rs1: 32'h00004d8e, rs2: 32'hbca10000, enc: 1'b0, id: 3'd2, exp_data: 32'h455313db};
        vecs[2] = '{src: 0, rs1: 32'h00000af2, rs2: 32'h5c220000, enc: 1'b1, id: 3'd1, exp_data: 32'h9d58dc9f};
        vecs[3] = '{src: 1, rs1: 32'h0000dc9f, rs2: 32'h9d580000, enc: 1'b0, id: 3'd6, exp_data: 32'h5c220af2};
        vecs[4] = '{src: 1, rs1: 32'h0000d4d4, rs2: 32'hd5d40000, enc: 1'b1, id: 3'd7, exp_data: 32'hd6d7d5d5};
        vecs[5] = '{src: 0, rs1: 32'h0000d5d5, rs2: 32'hd6d70000, enc: 1'b0, id: 3'd0, exp_data: 32'hd5d4d4d4};
        vecs[6] = '{src: 0, rs1: 32'habcd262d, rs2: 32'h4c319876, enc: 1'b1, id: 3'd3, exp_data: 32'hf8bd7e4d};
        vecs[7] = '{src: 1, rs1: 32'hffffc6c6, rs2: 32'hc6c6ffff, enc: 1'b1, id: 3'd4, exp_data: 32'hc6c6c6c6};
        none    = '{src: 0, rs1: 32'h0, rs2: 32'h0, enc: 1'b0, id: 3'd0, exp_data: 32'h0};

        reset = 1'b1; kill = 1'b0; rsp_ready = 1'b0;
        drive_req(0, 1'b0, none);
        drive_req(1, 1'b0, none);
        repeat (3) tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("reset busy", 32'(busy), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset mix_valid", 32'(mix_valid), 32'd0);
        check("reset mix_flush", 32'(mix_flush), 32'd1);
        check("reset mix_flush_data", mix_flush_data, 32'd0);
        check("reset mix_rs1", mix_rs1, 32'd0);
        check("reset rsp_data", rsp_data, 32'd0);

        // Table-driven single ops
        for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // kill blocks an accept in IDLE
        drive_req(0, 1'b1, vecs[0]);
        kill = 1'b1;
        #1;
        check("kill idle req0_ready", 32'(req0_ready), 32'd0);
        tick();
        kill = 1'b0;
        drive_req(0, 1'b0, none);
        #1;

        // kill in RUN at T+3
        accept_req(vecs[2], "kill", ok);
        tick();                     // T+2
        tick();                     // T+3
        kill = 1'b1;
        #1;
        check("kill mix_flush", 32'(mix_flush), 32'd1);
        tick();                     // T+4
        kill = 1'b0;
        #1;
        check("kill busy after", 32'(busy), 32'd0);
        check("kill mix_valid after", 32'(mix_valid), 32'd0);
        who = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid) who = 1;
            tick();
        end
        check("kill no response", 32'(who), 32'd0);
        run_op(vecs[3], "after kill");

        // Watchdog: datapath never completes
        tie_low = 1'b1;
        accept_req(vecs[4], "wdog", ok);
        for (int c = 1; c <= TIMEOUT; c++) begin
            check($sformatf("wdog T+%0d mix_flush", c), 32'(mix_flush), 32'(c == TIMEOUT));
            check($sformatf("wdog T+%0d rsp_valid", c), 32'(rsp_valid), 32'd0);
            tick();
        end
        check("wdog rsp_valid", 32'(rsp_valid), 32'd1);
        check("wdog rsp_err", 32'(rsp_err), 32'd1);
        check("wdog rsp_data", rsp_data, 32'd0);
        check("wdog rsp_id", 32'(rsp_id), 32'd7);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tie_low = 1'b0;
        #1;
        run_op(vecs[0], "after wdog");

        // Reset while a response is pending; both requesters wait at exit
        accept_req(vecs[0], "rst", ok);
        wait_rsp(lat);
        check("rst reached RESP", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        drive_req(0, 1'b1, vecs[0]);
        drive_req(1, 1'b1, vecs[1]);
        #1;
        check("rst req0_ready during reset", 32'(req0_ready), 32'd0);
        check("rst req1_ready during reset", 32'(req1_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rst rsp_valid after", 32'(rsp_valid), 32'd0);
        check("rst busy after", 32'(busy), 32'd0);

        // Both requesters valid every cycle: grants alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int w = 0; w < 20; w++) begin
                if (req0_ready || req1_ready) begin ok = 1'b1; break; end
                tick();
            end
            check($sformatf("rr%0d grant seen", k), 32'(ok), 32'd1);
            check($sformatf("rr%0d one-hot", k), 32'(req0_ready & req1_ready), 32'd0);
            check($sformatf("rr%0d grant to", k), 32'(req1_ready), 32'(k % 2));
            tick();                 // T+1
            check($sformatf("rr%0d no accept in RUN", k), 32'(req0_ready | req1_ready), 32'd0);
            wait_rsp(lat);
            check($sformatf("rr%0d latency", k), 32'(lat), 32'd5);
            check($sformatf("rr%0d rsp_src", k), 32'(rsp_src), 32'(k % 2));
            check($sformatf("rr%0d rsp_data", k), rsp_data, vecs[k % 2].exp_data);
            if (k == 0) begin
                held = rsp_data;
                for (int h = 0; h < 3; h++) begin
                    tick();
                    check($sformatf("hold%0d rsp_valid", h), 32'(rsp_valid), 32'd1);
                    check($sformatf("hold%0d rsp_data", h), rsp_data, held);
                    check($sformatf("hold%0d rsp_id", h), 32'(rsp_id), 32'd5);
                    check($sformatf("hold%0d no accept", h), 32'(req0_ready | req1_ready), 32'd0);
                end
            end
            rsp_ready = 1'b1;
            #1;
            check($sformatf("rr%0d no accept on exit", k), 32'(req0_ready | req1_ready), 32'd0);
            tick();
            rsp_ready = 1'b0;
            #1;
        end
        drive_req(0, 1'b0, none);
        drive_req(1, 1'b0, none);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
